// File: rtl/biu_constants_pkg.sv
// Shared BIU command encodings and arbiter owner IDs.
// Pure definitions, no logic or latency.
// No flow control; consumers apply their own handshakes.
package biu_constants_pkg;

   // Access size carried alongside every BIU command.
   typedef enum logic [1:0] {
      BIU_SIZE_BYTE  = 2'd0,
      BIU_SIZE_HWORD = 2'd1,
      BIU_SIZE_WORD  = 2'd2,
      BIU_SIZE_DWORD = 2'd3
   } biu_size_t;

   // Owner of an in-flight transaction, stored in the arbiter's owner FIFO.
   typedef enum logic {
      ARB_OWNER_IMEM = 1'b0,
      ARB_OWNER_DMEM = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/riscv_arb_owner_fifo.sv
// 1-bit owner-ID FIFO tracking issue order of outstanding BIU transactions.
// Head visible combinationally; push/pop take effect on the next rising edge.
// Push is dropped when full unless a pop happens in the same cycle; pop is ignored when empty.
module riscv_arb_owner_fifo #(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          wdata,
   input  logic          pop,
   output logic          rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/riscv_membus_arb.sv
// Arbitrates fetch and data-memory commands onto one BIU port, routing responses back in order.
// Zero latency: req->gnt and biu_ack/err->x_ack/err are combinational.
// Stalls both requesters when biu_rdy=0 or MAX_OUT transactions are outstanding with no response this cycle.
module riscv_membus_arb
   import biu_constants_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int MAX_OUT      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            imem_req,
   input  logic [XLEN-1:0] imem_adr,
   input  biu_size_t       imem_size,
   output logic            imem_gnt,
   output logic            imem_ack,
   output logic            imem_err,
   output logic [XLEN-1:0] imem_q,
   input  logic            dmem_req,
   input  logic [XLEN-1:0] dmem_adr,
   input  logic [XLEN-1:0] dmem_d,
   input  logic            dmem_we,
   input  biu_size_t       dmem_size,
   output logic            dmem_gnt,
   output logic            dmem_ack,
   output logic            dmem_err,
   output logic [XLEN-1:0] dmem_q,
   output logic            biu_req,
   output logic [XLEN-1:0] biu_adr,
   output logic [XLEN-1:0] biu_d,
   output logic            biu_we,
   output biu_size_t       biu_size,
   input  logic            biu_rdy,
   input  logic            biu_ack,
   input  logic            biu_err,
   input  logic [XLEN-1:0] biu_q
);

   localparam int            CW       = $clog2(MAX_OUT + 1);
   localparam int            SW       = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);
   localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

   logic            resp;
   logic            can_issue;
   logic            sel_imem;
   logic            accept;
   logic            pop;
   logic            fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   arb_owner_t      head_owner;
   arb_owner_t      push_owner;
   logic [SW-1:0]   starve_cnt;
   logic            issued_since_rst;

   assign resp       = biu_ack | biu_err;
   // A response retiring this cycle frees a slot for a same-cycle issue.
   assign can_issue  = (fifo_count != FULL_CNT) | resp;
   // dmem has priority unless imem has been passed over STARVE_LIMIT times in a row.
   assign sel_imem   = imem_req & (~dmem_req | (starve_cnt == LIMIT));
   // rst gating keeps the upstream view quiet while the requesters still hold req.
   assign biu_req    = (imem_req | dmem_req) & can_issue & ~rst;
   assign accept     = biu_req & biu_rdy;
   assign imem_gnt   = accept & sel_imem;
   assign dmem_gnt   = accept & ~sel_imem;
   // Responses with no recorded owner (e.g. leftovers from before reset) are dropped.
   assign pop        = resp & ~fifo_empty;
   assign head_owner = arb_owner_t'(fifo_rdata);
   assign push_owner = sel_imem ? ARB_OWNER_IMEM : ARB_OWNER_DMEM;

   riscv_arb_owner_fifo #(
      .DEPTH (MAX_OUT)
   ) u_owner_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata (push_owner),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Forward the selected requester's command; fetches never write.
   always_comb begin
      biu_adr  = dmem_adr;
      biu_d    = dmem_d;
      biu_we   = dmem_we;
      biu_size = dmem_size;
      if (sel_imem) begin
         biu_adr  = imem_adr;
         biu_d    = '0;
         biu_we   = 1'b0;
         biu_size = imem_size;
      end
   end

   // Steer the response to the owner at the FIFO head; the other side sees nothing.
   always_comb begin
      imem_ack = 1'b0;
      imem_err = 1'b0;
      imem_q   = '0;
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      dmem_q   = '0;
      if (pop) begin
         if (head_owner == ARB_OWNER_IMEM) begin
            imem_ack = biu_ack;
            imem_err = biu_err;
            imem_q   = biu_q;
         end else begin
            dmem_ack = biu_ack;
            dmem_err = biu_err;
            dmem_q   = biu_q;
         end
      end
   end

   // Count consecutive dmem wins while imem waits, saturating at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (imem_gnt || !imem_req) begin
         starve_cnt <= '0;
      end else if (dmem_gnt && starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Once something has issued since reset, an orphan response is a real protocol error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         issued_since_rst <= 1'b0;
      else if (accept) issued_since_rst <= 1'b1;
   end

   a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
      !(resp && fifo_empty && issued_since_rst));

   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(accept && fifo_full && !pop));

endmodule

// File: tb/tb_riscv_membus_arb.sv
// Bench for riscv_membus_arb: directed scenarios then random traffic against a queue-based model.
// Checks every cycle on the falling edge; model state advances on the rising edge.
// Requesters hold commands until granted; responses are only issued for outstanding commands.
module tb_riscv_membus_arb;
   import biu_constants_pkg::*;

   localparam int XLEN  = 32;
   localparam int MAXO  = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            imem_req, imem_gnt, imem_ack, imem_err;
   logic [XLEN-1:0] imem_adr, imem_q;
   biu_size_t       imem_size;
   logic            dmem_req, dmem_we, dmem_gnt, dmem_ack, dmem_err;
   logic [XLEN-1:0] dmem_adr, dmem_d, dmem_q;
   biu_size_t       dmem_size;
   logic            biu_req, biu_we, biu_rdy, biu_ack, biu_err;
   logic [XLEN-1:0] biu_adr, biu_d, biu_q;
   biu_size_t       biu_size;

   riscv_membus_arb #(.XLEN(XLEN), .MAX_OUT(MAXO), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_adr(imem_adr), .imem_size(imem_size),
      .imem_gnt(imem_gnt), .imem_ack(imem_ack), .imem_err(imem_err), .imem_q(imem_q),
      .dmem_req(dmem_req), .dmem_adr(dmem_adr), .dmem_d(dmem_d), .dmem_we(dmem_we),
      .dmem_size(dmem_size), .dmem_gnt(dmem_gnt), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
      .dmem_q(dmem_q),
      .biu_req(biu_req), .biu_adr(biu_adr), .biu_d(biu_d), .biu_we(biu_we),
      .biu_size(biu_size), .biu_rdy(biu_rdy), .biu_ack(biu_ack), .biu_err(biu_err),
      .biu_q(biu_q)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: in-order owner queue (0=imem, 1=dmem) and a starvation tally.
   int own_q[$];
   int starve = 0;

   // DUT outputs captured at the last checked falling edge.
   logic            c_ig, c_dg, c_ia, c_da, c_ie, c_de, c_breq;
   logic [XLEN-1:0] c_adr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: check outputs against the model, then advance the model.
   task automatic step();
      logic resp, can, pick_i, e_breq, e_ig, e_dg;
      int   head;
      @(negedge clk);
      c_ig = imem_gnt; c_dg = dmem_gnt; c_ia = imem_ack; c_da = dmem_ack;
      c_ie = imem_err; c_de = dmem_err; c_breq = biu_req; c_adr = biu_adr;
      if (rst) begin
         chk("rst_biu_req", biu_req, 0);
         chk("rst_gnt", {imem_gnt, dmem_gnt}, 0);
         chk("rst_ack_err", {imem_ack, dmem_ack, imem_err, dmem_err}, 0);
         own_q.delete();
         starve = 0;
         @(posedge clk);
         #1;
         return;
      end
      resp   = biu_ack | biu_err;
      can    = (own_q.size() < MAXO) || (own_q.size() == MAXO && resp);
      e_breq = (imem_req | dmem_req) & can;
      pick_i = imem_req && (!dmem_req || starve == LIMIT);
      e_ig   = e_breq & biu_rdy & pick_i;
      e_dg   = e_breq & biu_rdy & !pick_i;
      chk("biu_req", biu_req, e_breq);
      chk("imem_gnt", imem_gnt, e_ig);
      chk("dmem_gnt", dmem_gnt, e_dg);
      if (e_breq) begin
         chk("biu_adr", biu_adr, pick_i ? imem_adr : dmem_adr);
         chk("biu_we", biu_we, pick_i ? 1'b0 : dmem_we);
         chk("biu_d", biu_d, pick_i ? '0 : dmem_d);
         chk("biu_size", biu_size, pick_i ? imem_size : dmem_size);
      end
      head = (resp && own_q.size() > 0) ? own_q[0] : -1;
      chk("imem_ack", imem_ack, biu_ack && head == 0);
      chk("imem_err", imem_err, biu_err && head == 0);
      chk("dmem_ack", dmem_ack, biu_ack && head == 1);
      chk("dmem_err", dmem_err, biu_err && head == 1);
      if (head == 0) chk("imem_q", imem_q, biu_q);
      if (head == 1) chk("dmem_q", dmem_q, biu_q);
      @(posedge clk);
      if (head >= 0) void'(own_q.pop_front());
      if (e_ig) own_q.push_back(0);
      if (e_dg) own_q.push_back(1);
      if (e_ig || !imem_req)              starve = 0;
      else if (e_dg && starve < LIMIT)    starve++;
      #1;
   endtask

   task automatic idle();
      imem_req = 1'b0; dmem_req = 1'b0; biu_ack = 1'b0; biu_err = 1'b0;
   endtask

   // Acknowledge everything outstanding with requests dropped.
   task automatic drain();
      idle();
      for (int i = 0; i < 8 && own_q.size() > 0; i++) begin
         biu_ack = 1'b1;
         step();
      end
      biu_ack = 1'b0;
   endtask

   initial begin
      logic [9:0] seq;
      logic [2:0] seq3;
      int         gcount;

      rst = 1'b1; idle(); biu_rdy = 1'b1; biu_q = '0;
      imem_adr = 32'h1000; imem_size = BIU_SIZE_WORD;
      dmem_adr = 32'h2000; dmem_d = 32'h55AA_1234; dmem_we = 1'b0; dmem_size = BIU_SIZE_WORD;

      // Reset with both requesters active: everything must stay quiet.
      imem_req = 1'b1; dmem_req = 1'b1;
      step(); step();
      rst = 1'b0; idle();
      step();
      chk("idle_biu_req", c_breq, 0);

      // Single dmem read at 0x100, ack three cycles after the grant.
      dmem_req = 1'b1; dmem_adr = 32'h100;
      step();
      chk("t2_dmem_gnt_c0", c_dg, 1);
      chk("t2_biu_adr_c0", c_adr, 32'h100);
      dmem_req = 1'b0;
      step(); chk("t2_no_ack_c1", c_da, 0);
      step(); chk("t2_no_ack_c2", c_da, 0);
      biu_ack = 1'b1; biu_q = 32'hDEAD_BEEF;
      step();
      chk("t2_dmem_ack_c3", c_da, 1);
      chk("t2_imem_ack_c3", c_ia, 0);
      biu_ack = 1'b0;
      dmem_adr = 32'h2000;

      // Both requesting with immediate acks: starvation forces every fifth grant to imem.
      imem_req = 1'b1; dmem_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         biu_ack = (own_q.size() > 0);
         biu_q   = 32'hA000_0000 + i;
         step();
         seq[i] = c_ig;
      end
      chk("t3_grant_seq", seq, 10'b10_0001_0000);
      drain();

      // MAX_OUT outstanding with acks withheld, then in-order retirement I,D,I.
      imem_req = 1'b1;
      step(); chk("t4_accept0_imem", c_ig, 1);
      imem_req = 1'b0; dmem_req = 1'b1;
      step(); chk("t4_accept1_dmem", c_dg, 1);
      dmem_req = 1'b0; imem_req = 1'b1;
      for (int i = 2; i < 5; i++) begin
         step();
         chk("t4_full_biu_req", c_breq, 0);
         chk("t4_full_gnt", {c_ig, c_dg}, 0);
      end
      biu_ack = 1'b1; biu_q = 32'h1111_0001;
      step();
      chk("t4_c5_imem_ack", c_ia, 1);
      chk("t4_c5_third_accept", c_ig, 1);
      imem_req = 1'b0; biu_q = 32'h2222_0002;
      step(); chk("t4_c6_dmem_ack", c_da, 1);
      biu_q = 32'h3333_0003;
      step(); chk("t4_c7_imem_ack", c_ia, 1);
      biu_ack = 1'b0;

      // Error on the imem transaction, then ack on the dmem one.
      imem_req = 1'b1; step(); chk("t5_imem_gnt", c_ig, 1);
      imem_req = 1'b0; dmem_req = 1'b1; step(); chk("t5_dmem_gnt", c_dg, 1);
      dmem_req = 1'b0; biu_err = 1'b1;
      step();
      chk("t5_imem_err", c_ie, 1);
      chk("t5_dmem_err", c_de, 0);
      biu_err = 1'b0; biu_ack = 1'b1;
      step();
      chk("t5_dmem_ack", c_da, 1);
      chk("t5_imem_ack", c_ia, 0);
      biu_ack = 1'b0;

      // Reset with two outstanding; stray ack afterwards must not reach either side.
      imem_req = 1'b1; step();
      imem_req = 1'b0; dmem_req = 1'b1; step();
      imem_req = 1'b1; dmem_req = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; idle();
      biu_ack = 1'b1;
      step();
      chk("t6_stray_ack", {c_ia, c_da, c_ie, c_de}, 0);
      biu_ack = 1'b0;
      imem_req = 1'b1; gcount = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         gcount += int'(c_ig);
      end
      chk("t6_accepts_after_rst", gcount, MAXO);
      drain();

      // biu_rdy low for 10 cycles: no grants, fields parked on dmem, starvation tally frozen.
      imem_req = 1'b1; dmem_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         biu_ack = (own_q.size() > 0);
         step();
      end
      biu_rdy = 1'b0; gcount = 0;
      for (int i = 0; i < 10; i++) begin
         biu_ack = (own_q.size() > 0);
         step();
         gcount += int'(c_ig) + int'(c_dg);
      end
      chk("t7_no_gnt_stalled", gcount, 0);
      chk("t7_fields_on_dmem", c_adr, 32'h2000);
      biu_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         biu_ack = (own_q.size() > 0);
         step();
         seq3[i] = c_ig;
      end
      chk("t7_resume_seq", seq3, 3'b100);
      drain();

      // Random traffic against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!imem_req || c_ig) begin
            imem_req  = ($urandom_range(0, 2) != 0);
            imem_adr  = $urandom;
            imem_size = biu_size_t'($urandom_range(0, 3));
         end
         if (!dmem_req || c_dg) begin
            dmem_req  = ($urandom_range(0, 2) != 0);
            dmem_adr  = $urandom;
            dmem_d    = $urandom;
            dmem_we   = $urandom_range(0, 1) == 1;
            dmem_size = biu_size_t'($urandom_range(0, 3));
         end
         biu_rdy = ($urandom_range(0, 3) != 0);
         biu_q   = $urandom;
         biu_ack = 1'b0; biu_err = 1'b0;
         if (own_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 7) == 0) biu_err = 1'b1;
            else                           biu_ack = 1'b1;
         end
         rst = ($urandom_range(0, 299) == 0);
         if (rst) begin
            biu_ack = 1'b0; biu_err = 1'b0;
         end
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_membus_arb.md
# riscv_membus_arb

- Two-requester arbiter sharing one BIU port between the instruction-fetch port and the data-memory port of `riscv_core`.
- Commands are granted combinationally by priority with anti-starvation, and forwarded to a single downstream port.
- Each accepted command's owner ID is queued in a small FIFO, so responses (ack/err/q) route back in order; up to `MAX_OUT` transactions may be outstanding.
- Sits between the core's `if_*`/`dmem_*` memory-side logic and the BIU.

## Interface
- `XLEN`, 32, address/data width
- `MAX_OUT`, 2, max outstanding transactions (power of 2, ≥1)
- `STARVE_LIMIT`, 4, consecutive dmem grants while imem waits before imem is forced
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `imem_req`  in  1  fetch command valid
- `imem_adr`  in  XLEN  fetch address
- `imem_size`  in  biu_size_t  fetch size
- `imem_gnt`  out  1  fetch command accepted this cycle
- `imem_ack`  out  1  fetch response valid
- `imem_err`  out  1  fetch bus error
- `imem_q`  out  XLEN  fetch read data
- `dmem_req`  in  1  data command valid
- `dmem_adr`  in  XLEN  data address
- `dmem_d`  in  XLEN  write data
- `dmem_we`  in  1  write enable
- `dmem_size`  in  biu_size_t  access size
- `dmem_gnt`  out  1  data command accepted
- `dmem_ack`  out  1  data response valid
- `dmem_err`  out  1  data bus error
- `dmem_q`  out  XLEN  data read data
- `biu_req`  out  1  downstream command valid
- `biu_adr`, `biu_d`  out  XLEN  downstream address / write data
- `biu_we`  out  1  downstream write enable
- `biu_size`  out  biu_size_t  downstream size
- `biu_rdy`  in  1  downstream accepts command this cycle
- `biu_ack`, `biu_err`  in  1  downstream response / error (exclusive)
- `biu_q`  in  XLEN  downstream read data

## Operation
- Requester holds `req` and command fields stable until its `gnt`.
- `can_issue` = outstanding count < `MAX_OUT`, or (count == `MAX_OUT` and a response completes this cycle).
- Selection when both requesters are active: dmem wins, unless `starve_cnt` == `STARVE_LIMIT`, in which case imem wins.
- `biu_req` = (`imem_req` | `dmem_req`) & `can_issue`.
- The `biu_*` command fields mux from the selected requester.
- For imem commands, `biu_we`=0 and `biu_d`=0.
- `x_gnt` = selected & `biu_req` & `biu_rdy`.
- On accept, the owner ID (0=imem, 1=dmem) is pushed to the owner FIFO (depth `MAX_OUT`).
- On `biu_ack|biu_err`:
  - the FIFO head is popped;
  - the matching `x_ack`/`x_err` is driven and `x_q`=`biu_q`;
  - the non-owner's ack/err stay 0.
- A response with an empty FIFO is ignored. It is flagged by a simulation-only assertion.
- `starve_cnt` update:
  - increments on a dmem grant while `imem_req`=1;
  - clears on an imem grant or when `imem_req`=0;
  - saturates at `STARVE_LIMIT`.
- Push and pop in the same cycle leave the count unchanged and keep FIFO order.

## Timing
- Grant path is combinational: `req` → `gnt` in the same cycle, given `biu_rdy`.
- Response path is combinational: `biu_ack` → `x_ack` with zero latency.
- Owner FIFO, count and `starve_cnt` update on the rising edge of `clk`.
- Back-to-back accepts are allowed every cycle while `can_issue` holds.
- Reset values:
  - count=0, FIFO pointers 0, `starve_cnt`=0;
  - all `gnt`/`ack`/`err` outputs 0;
  - `biu_req`=0 while no requester is active.
- Reset asserted mid-transaction flushes the FIFO. Responses arriving after reset are dropped; the downstream BIU is reset by the same `rst`.
- FIFO full without a response: `biu_req`=0 and both `gnt`=0.
- FIFO pointers wrap modulo `MAX_OUT`.

## Structure
- Owner-ID encoding (`ARB_OWNER_IMEM`=0, `ARB_OWNER_DMEM`=1) goes in `biu_constants_pkg`, alongside `biu_size_t`.
- One sub-module: `riscv_arb_owner_fifo`, a 1-bit-wide synchronous FIFO with count, full/empty and same-cycle push/pop.

## Test plan
- Single dmem read at 0x100, `biu_rdy`=1, ack 3 cycles later with `biu_q`=0xDEADBEEF:
  - `dmem_gnt` in cycle 0;
  - `dmem_ack` plus `dmem_q`=0xDEADBEEF in cycle 3;
  - `imem_ack` stays 0.
- Both requesting continuously with immediate acks, `STARVE_LIMIT`=4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- `MAX_OUT`=2 and acks withheld:
  - two accepts, then `biu_req`=0;
  - an ack in cycle 5 allows a third accept in cycle 5;
  - responses route I,D,I in issue order.
- imem accepted, then dmem accepted, then `biu_err` followed by `biu_ack` → `imem_err`=1, then `dmem_ack`=1.
- `rst` pulsed with 2 outstanding:
  - count returns to 0 and all outputs are 0;
  - a later stray `biu_ack` produces no upstream ack.
- `biu_rdy`=0 for 10 cycles with both requesting → no `gnt`, `starve_cnt` unchanged, command fields stable on dmem.
